lifo_stack: RTL and testbench

- Synchronous LIFO stack with one push/pop control bit and a global enable.
- Top-of-stack entry is continuously presented on data_out.
- Serves as the CPU's hardware stack for call/return and data pushes.
- Storage is an internal register array indexed by a stack pointer.

---
 rtl/stack_pkg.sv | 43 ++++
 rtl/lifo_stack_mem.sv | 28 ++
 rtl/lifo_stack.sv | 91 +++++++++
 tb/tb_lifo_stack.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared constants, operation encoding and decode helper for the LIFO stack.
// Pointer width is derived from depth so it can hold every count 0..DEPTH.
package stack_pkg;

    localparam logic ENABLE     = 1'b1;
    localparam logic DISABLE    = 1'b0;
    localparam logic STACK_PUSH = 1'b1;
    localparam logic STACK_POP  = 1'b0;

    localparam int STACK_DATA_WIDTH = 16;
    localparam int STACK_DEPTH      = 16;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REJECT
    } stack_op_e;

    function automatic int stack_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // A rejected op is an enabled push on a full stack or pop on an empty one.
    function automatic stack_op_e decode_op(
        input logic en,
        input logic push,
        input logic full,
        input logic empty
    );
        stack_op_e op;
        op = OP_IDLE;
        case ({en, push})
            {ENABLE, STACK_PUSH}:  op = full  ? OP_REJECT : OP_PUSH;
            {ENABLE, STACK_POP}:   op = empty ? OP_REJECT : OP_POP;
            {DISABLE, STACK_PUSH}: op = OP_IDLE;
            {DISABLE, STACK_POP}:  op = OP_IDLE;
            default:               op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/lifo_stack_mem.sv
// DEPTH x DATA_WIDTH register file: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module lifo_stack_mem
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = STACK_DATA_WIDTH,
    parameter int DEPTH      = STACK_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack with registered top-of-stack output and flags decoded from the pointer.
// Define STACK_ERR_FLAG_EN to add a sticky overflow/underflow error output 'err'.
module lifo_stack
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = STACK_DATA_WIDTH,
    parameter int DEPTH      = STACK_DEPTH,
    parameter int PTR_WIDTH  = stack_ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
`ifdef STACK_ERR_FLAG_EN
    ,
    output logic                  err
`endif
);

    localparam int ADDR_WIDTH = PTR_WIDTH - 1;

    logic [PTR_WIDTH-1:0]  sp;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_en;
    stack_op_e             op;

    assign empty = (sp == '0);
    assign full  = (sp == PTR_WIDTH'(DEPTH));

    always_comb begin
        op = decode_op(en, push, full, empty);
    end

    // Writes go to mem[sp]; the read port looks two below sp so that a pop
    // can load the entry that becomes the new top in the same edge.
    assign wr_en   = (op == OP_PUSH);
    assign wr_addr = sp[ADDR_WIDTH-1:0];
    assign rd_addr = wr_addr - ADDR_WIDTH'(2);

    lifo_stack_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (data_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp       <= '0;
            data_out <= '0;
        end else begin
            case (op)
                OP_PUSH: begin
                    sp       <= sp + PTR_WIDTH'(1);
                    data_out <= data_in;
                end
                OP_POP: begin
                    sp       <= sp - PTR_WIDTH'(1);
                    data_out <= (sp > PTR_WIDTH'(1)) ? rd_data : '0;
                end
                default: begin
                    sp       <= sp;
                    data_out <= data_out;
                end
            endcase
        end
    end

`ifdef STACK_ERR_FLAG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (op == OP_REJECT) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Scoreboard bench for lifo_stack: directed plan followed by random traffic,
// checked against a queue-based stack model.
module tb_lifo_stack;
    import stack_pkg::*;

    localparam int DW    = STACK_DATA_WIDTH;
    localparam int DEPTH = STACK_DEPTH;

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
        logic          f;
        logic          er;
        string         tag;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          en;
    logic          push;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
    logic          err;

    logic [DW-1:0] model_q[$];
    logic          m_err;
    exp_t          exp_q[$];
    int            total;
    int            bad;

    lifo_stack dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .push     (push),
        .data_in  (data_in),
        .data_out (data_out),
        .empty    (empty),
        .full     (full)
`ifdef STACK_ERR_FLAG_EN
        ,
        .err      (err)
`endif
    );

`ifndef STACK_ERR_FLAG_EN
    assign err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t make_exp(input string tag);
        exp_t r;
        r.d   = (model_q.size() > 0) ? model_q[model_q.size()-1] : '0;
        r.e   = (model_q.size() == 0);
        r.f   = (model_q.size() == DEPTH);
        r.er  = m_err;
        r.tag = tag;
        return r;
    endfunction

    task automatic checkOutput(input exp_t x);
        logic ok;
        ok = (data_out === x.d) && (empty === x.e) && (full === x.f);
`ifdef STACK_ERR_FLAG_EN
        ok = ok && (err === x.er);
`endif
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL %s: got data_out=%h empty=%b full=%b err=%b, want data_out=%h empty=%b full=%b err=%b",
                     x.tag, data_out, empty, full, err, x.d, x.e, x.f, x.er);
        end
    endtask

    // One operation per cycle; the model result is queued for the monitor.
    task automatic applyStimulus(input logic e, input logic p, input logic [DW-1:0] d, input string tag);
        @(negedge clk);
        en      = e;
        push    = p;
        data_in = d;
        if (e) begin
            if (p) begin
                if (model_q.size() < DEPTH) model_q.push_back(d);
                else m_err = 1'b1;
            end else begin
                if (model_q.size() > 0) void'(model_q.pop_back());
                else m_err = 1'b1;
            end
        end
        exp_q.push_back(make_exp(tag));
    endtask

    task automatic applyReset(input string tag);
        @(negedge clk);
        en    = 1'b0;
        reset = 1'b1;
        model_q.delete();
        m_err = 1'b0;
        #1;
        checkOutput(make_exp(tag));
        #2;
        reset = 1'b0;
    endtask

    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        exp_t rst_exp;
        total   = 0;
        bad     = 0;
        m_err   = 1'b0;
        reset   = 1'b1;
        en      = 1'b0;
        push    = 1'b0;
        data_in = '0;
        #12;
        rst_exp.d = '0; rst_exp.e = 1'b1; rst_exp.f = 1'b0; rst_exp.er = 1'b0; rst_exp.tag = "reset_state";
        checkOutput(rst_exp);
        reset = 1'b0;

        applyStimulus(ENABLE, STACK_POP, 16'h0, "idle_pop0");
        applyStimulus(ENABLE, STACK_POP, 16'h0, "idle_pop1");
        for (int i = 0; i < 4; i++) applyStimulus(ENABLE, STACK_PUSH, DW'(16'h11 + i), "push_seq");
        applyStimulus(ENABLE, STACK_POP, 16'h0, "pop_to_13");
        applyStimulus(ENABLE, STACK_POP, 16'h0, "pop_to_12");
        applyStimulus(DISABLE, STACK_POP, 16'h0, "en_gated");
        applyStimulus(ENABLE, STACK_POP, 16'h0, "pop_to_11");
        applyStimulus(ENABLE, STACK_POP, 16'h0, "pop_to_empty");
        for (int i = 0; i < DEPTH; i++) applyStimulus(ENABLE, STACK_PUSH, DW'(16'h100 + i), "fill");
        applyStimulus(ENABLE, STACK_PUSH, 16'hAAAA, "push_when_full");
        applyStimulus(ENABLE, STACK_POP, 16'h0, "pop_from_full");
        applyReset("reset_clear");
        for (int i = 0; i < 3; i++) applyStimulus(ENABLE, STACK_PUSH, DW'(16'h20 + i), "pre_reset_push");
        applyReset("async_reset_mid");
        applyStimulus(ENABLE, STACK_PUSH, 16'h55, "push_after_reset");
        applyStimulus(ENABLE, STACK_POP, 16'h0, "pop_after_reset");

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                applyReset("rand_reset");
            end else begin
                applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 99) < 55,
                              DW'($urandom), "random_op");
            end
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: pending=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
